// File: rtl/l1_mem_responder.sv
// l1_mem_responder: 128-bit block memory behind the L1 cache mem_read/mem_write/mem_ready port.
// Latency: mem_ready pulses exactly LATENCY cycles after a request is accepted in IDLE.
// Backpressure: one transaction in flight; requests seen outside IDLE are not accepted.
module l1_mem_responder #(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               proc_reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [27:0]        mem_addr,
    input  logic [127:0]       mem_wdata,
    output logic [127:0]       mem_rdata,
    output logic               mem_ready,
    output logic               busy,
    output logic               proto_err,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int         DEPTH  = 1 << ADDR_W;
    // Counter preload; the READY transition happens on the edge where it reads 1.
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t              state;
    logic [7:0]          wait_cnt;
    logic                op_wr;
    logic [27:0]         addr_q;
    logic [127:0]        wdata_q;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   req_idx;
    logic                req;

    // Block storage has no reset so it can map onto RAM; the valid bits stand in
    // for clearing it, so a never-written (or reset) entry reads back as zero.
    logic [127:0]        store [DEPTH];
    logic [DEPTH-1:0]    blk_vld;
    logic                commit;

    assign idx     = addr_q[ADDR_W-1:0];
    assign req_idx = mem_addr[ADDR_W-1:0];
    assign req     = mem_read | mem_write;
    assign commit  = (state == READY) && op_wr;

    // Write data lands on the edge leaving READY, so a read accepted in the
    // following IDLE cycle already sees it.
    always_ff @(posedge clk) begin
        if (!proc_reset && commit) begin
            store[idx] <= wdata_q;
        end
    end

    // Transaction FSM with registered outputs, counters and per-block valid bits.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_rdata <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
            blk_vld   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (req) begin
                        // A simultaneous read+write is flagged and served as a write.
                        op_wr    <= mem_write;
                        addr_q   <= mem_addr;
                        wdata_q  <= mem_wdata;
                        wait_cnt <= LAT_M1;
                        busy     <= 1'b1;
                        if (mem_read && mem_write) begin
                            proto_err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state     <= READY;
                            mem_ready <= 1'b1;
                            if (!mem_write) begin
                                mem_rdata <= blk_vld[req_idx] ? store[req_idx] : '0;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                    // The requester must hold the request and address steady here;
                    // the latched copy is used regardless.
                    if (!req || (mem_addr != addr_q)) begin
                        proto_err <= 1'b1;
                    end
                    if (wait_cnt == 8'd1) begin
                        state     <= READY;
                        mem_ready <= 1'b1;
                        if (!op_wr) begin
                            mem_rdata <= blk_vld[idx] ? store[idx] : '0;
                        end
                    end
                end

                READY: begin
                    // Always one cycle; a request still held here is only
                    // re-evaluated once back in IDLE.
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    if (op_wr) begin
                        blk_vld[idx] <= 1'b1;
                        wr_count     <= wr_count + 1'b1;
                    end else begin
                        rd_count <= rd_count + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_responder.sv
// tb_l1_mem_responder: scoreboard bench for two responders (LATENCY=4/CNT_W=16 and LATENCY=1/CNT_W=4).
// Latency: expected read data is queued when a request is driven and popped at its mem_ready.
// Backpressure: requests are held until mem_ready, then dropped at the start of the next cycle.
module tb_l1_mem_responder;

    logic          clk;
    logic          rst0, rd0, wr0, rdy0, busy0, perr0;
    logic [27:0]   addr0;
    logic [127:0]  wdata0, rdata0;
    logic [15:0]   rdc0, wrc0;
    logic          rst1, rd1, wr1, rdy1, busy1, perr1;
    logic [27:0]   addr1;
    logic [127:0]  wdata1, rdata1;
    logic [3:0]    rdc1, wrc1;

    int            n_vec = 0;
    int            n_err = 0;
    int            rdy0_cnt = 0;

    logic [127:0]  model0 [64];
    logic [127:0]  model1 [64];
    logic [127:0]  last0, last1;
    logic [127:0]  exp_q [$];

    l1_mem_responder #(.ADDR_W(6), .LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .proc_reset(rst0), .mem_read(rd0), .mem_write(wr0),
        .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata0),
        .mem_ready(rdy0), .busy(busy0), .proto_err(perr0),
        .rd_count(rdc0), .wr_count(wrc0)
    );

    l1_mem_responder #(.ADDR_W(6), .LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .proc_reset(rst1), .mem_read(rd1), .mem_write(wr1),
        .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
        .mem_ready(rdy1), .busy(busy1), .proto_err(perr1),
        .rd_count(rdc1), .wr_count(wrc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts mem_ready pulses of the LATENCY=4 instance.
    always @(negedge clk) if (rdy0 === 1'b1) rdy0_cnt <= rdy0_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input bit s);
        if (s) begin rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; end
        else   begin rst0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        if (s) rst1 = 1'b0; else rst0 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (s) model1[i] = '0; else model0[i] = '0;
        end
        if (s) last1 = '0; else last0 = '0;
    endtask

    // Waits (bounded) for mem_ready, returns cycles counted and mem_rdata, then drops the request.
    task automatic wait_ready(input bit s, output int lat, output logic [127:0] got);
        lat = 0;
        got = '0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if ((s ? rdy1 : rdy0) === 1'b1) begin
                lat = n;
                got = s ? rdata1 : rdata0;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (s) begin rd1 = 1'b0; wr1 = 1'b0; end
        else   begin rd0 = 1'b0; wr0 = 1'b0; end
    endtask

    // op: 0 read, 1 write, 2 read+write. Queues the expected mem_rdata at mem_ready.
    task automatic issue(input bit s, input int op, input logic [27:0] a, input logic [127:0] d,
                         output int lat, output logic [127:0] got);
        logic [127:0] e;
        if (s) begin
            e = (op == 0) ? model1[a[5:0]] : last1;
            if (op != 0) model1[a[5:0]] = d; else last1 = e;
            rd1 = (op != 1); wr1 = (op != 0); addr1 = a; wdata1 = d;
        end else begin
            e = (op == 0) ? model0[a[5:0]] : last0;
            if (op != 0) model0[a[5:0]] = d; else last0 = e;
            rd0 = (op != 1); wr0 = (op != 0); addr0 = a; wdata0 = d;
        end
        exp_q.push_back(e);
        wait_ready(s, lat, got);
    endtask

    task automatic test_reset();
        do_reset(0);
        do_reset(1);
        n_vec++;
        if ({rdata0, rdy0, busy0, perr0, rdc0, wrc0} !== '0) begin
            n_err++;
            $display("FAIL reset0: got rdata=%0h rdy=%b busy=%b perr=%b rd=%0d wr=%0d, expected all zero",
                     rdata0, rdy0, busy0, perr0, rdc0, wrc0);
        end
        n_vec++;
        if ({rdata1, rdy1, busy1, perr1, rdc1, wrc1} !== '0) begin
            n_err++;
            $display("FAIL reset1: got rdata=%0h rdy=%b busy=%b perr=%b rd=%0d wr=%0d, expected all zero",
                     rdata1, rdy1, busy1, perr1, rdc1, wrc1);
        end
    endtask

    task automatic test_read_latency();
        logic [127:0] got, e;
        e = model0[5];
        exp_q.push_back(e);
        last0 = e;
        rd0 = 1'b1; addr0 = 28'h0000005;
        @(negedge clk);
        n_vec++;
        if (busy0 !== 1'b0) begin
            n_err++; $display("FAIL busy_pre: got %b expected 0", busy0);
        end
        got = '0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (busy0 !== 1'b1 || rdy0 !== (n == 4)) begin
                n_err++;
                $display("FAIL rd_lat cycle+%0d: got busy=%b rdy=%b expected busy=1 rdy=%b", n, busy0, rdy0, (n == 4));
            end
            if (n == 4) got = rdata0;
        end
        @(posedge clk);
        #1;
        rd0 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rdy0 !== 1'b0 || busy0 !== 1'b0 || rdc0 !== 16'd1 || wrc0 !== 16'd0) begin
            n_err++;
            $display("FAIL rd_done: got rdy=%b busy=%b rd=%0d wr=%0d expected 0 0 1 0", rdy0, busy0, rdc0, wrc0);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL rd_data: got %0h expected %0h", got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int l1, l2;
        logic [127:0] g1, g2, e;
        issue(0, 1, 28'h0000003, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, l1, g1);
        issue(0, 0, 28'h0000003, '0, l2, g2);
        n_vec++;
        if (l2 !== 4 || (l1 + 1 + l2) !== 9) begin
            n_err++; $display("FAIL b2b_lat: got %0d+1+%0d expected 4+1+4", l1, l2);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (g1 !== e) begin
            n_err++; $display("FAIL wr_rdata_hold: got %0h expected %0h", g1, e);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (g2 !== e) begin
            n_err++; $display("FAIL rd_after_wr: got %0h expected %0h", g2, e);
        end
        n_vec++;
        if (wrc0 !== 16'd1 || rdc0 !== 16'd2) begin
            n_err++; $display("FAIL b2b_counts: got wr=%0d rd=%0d expected wr=1 rd=2", wrc0, rdc0);
        end
    endtask

    task automatic test_alias();
        int l;
        logic [127:0] g, e;
        issue(0, 1, 28'h0000041, 128'h1234, l, g);
        e = exp_q.pop_front();
        issue(0, 0, 28'h0000001, '0, l, g);
        e = exp_q.pop_front();
        n_vec++;
        if (g !== e) begin
            n_err++; $display("FAIL alias: got %0h expected %0h", g, e);
        end
    endtask

    task automatic test_violation();
        int l, n;
        logic [127:0] g, e;
        do_reset(0);
        issue(0, 2, 28'h0000007, 128'h7777_0000_1111_2222, l, g);
        e = exp_q.pop_front();
        n_vec++;
        if (l !== 4 || g !== e || perr0 !== 1'b1 || wrc0 !== 16'd1 || rdc0 !== 16'd0) begin
            n_err++;
            $display("FAIL both_req: got lat=%0d rdata=%0h perr=%b wr=%0d rd=%0d expected 4 %0h 1 1 0",
                     l, g, perr0, wrc0, rdc0, e);
        end
        issue(0, 0, 28'h0000007, '0, l, g);
        e = exp_q.pop_front();
        n_vec++;
        if (g !== e) begin
            n_err++; $display("FAIL both_req_store: got %0h expected %0h", g, e);
        end
        // request dropped in the first WAIT cycle
        e = model0[8]; exp_q.push_back(e); last0 = e;
        rd0 = 1'b1; addr0 = 28'h0000008;
        @(posedge clk); #1;
        rd0 = 1'b0;
        wait_ready(0, n, g);
        e = exp_q.pop_front();
        n_vec++;
        if (n + 1 !== 4 || g !== e || perr0 !== 1'b1 || rdc0 !== 16'd2) begin
            n_err++;
            $display("FAIL drop_wait: got lat=%0d rdata=%0h perr=%b rd=%0d expected 4 %0h 1 2", n + 1, g, perr0, rdc0, e);
        end
        do_reset(0);
        issue(0, 1, 28'h0000009, 128'h9999_AAAA_5555_6666, l, g);
        e = exp_q.pop_front();
        n_vec++;
        if (perr0 !== 1'b0) begin
            n_err++; $display("FAIL clean_write_perr: got %b expected 0", perr0);
        end
        // address changed in the first WAIT cycle; latched index 9 is served
        e = model0[9]; exp_q.push_back(e); last0 = e;
        rd0 = 1'b1; addr0 = 28'h0000009;
        @(posedge clk); #1;
        addr0 = 28'h000004A;
        wait_ready(0, n, g);
        e = exp_q.pop_front();
        n_vec++;
        if (n + 1 !== 4 || g !== e || perr0 !== 1'b1) begin
            n_err++;
            $display("FAIL addr_chg: got lat=%0d rdata=%0h perr=%b expected 4 %0h 1", n + 1, g, perr0, e);
        end
    endtask

    task automatic test_reset_mid();
        int c0, l;
        logic [127:0] g, e;
        c0 = rdy0_cnt;
        wr0 = 1'b1; addr0 = 28'h0000002; wdata0 = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_reset(0);
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (rdy0_cnt !== c0 || rdc0 !== 16'd0 || wrc0 !== 16'd0 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got pulses=%0d rd=%0d wr=%0d busy=%b expected 0 0 0 0",
                     rdy0_cnt - c0, rdc0, wrc0, busy0);
        end
        issue(0, 0, 28'h0000002, '0, l, g);
        e = exp_q.pop_front();
        n_vec++;
        if (g !== e) begin
            n_err++; $display("FAIL reset_mid_store: got %0h expected %0h", g, e);
        end
    endtask

    task automatic test_lat1_wrap();
        int l;
        logic [127:0] g, e;
        do_reset(1);
        for (int i = 0; i < 15; i++) begin
            issue(1, 1, 28'(i), {4{32'(i) + 32'hA0}}, l, g);
            e = exp_q.pop_front();
            n_vec++;
            if (l !== 1 || g !== e) begin
                n_err++; $display("FAIL lat1_wr%0d: got lat=%0d rdata=%0h expected 1 %0h", i, l, g, e);
            end
        end
        n_vec++;
        if (wrc1 !== 4'd15) begin
            n_err++; $display("FAIL wr_count_max: got %0d expected 15", wrc1);
        end
        issue(1, 1, 28'h0000020, 128'hCAFE, l, g);
        e = exp_q.pop_front();
        n_vec++;
        if (l !== 1 || wrc1 !== 4'd0) begin
            n_err++; $display("FAIL wr_count_wrap: got lat=%0d wr=%0d expected 1 0", l, wrc1);
        end
        issue(1, 0, 28'h0000003, '0, l, g);
        e = exp_q.pop_front();
        n_vec++;
        if (l !== 1 || g !== e || rdc1 !== 4'd1) begin
            n_err++; $display("FAIL lat1_rd: got lat=%0d rdata=%0h rd=%0d expected 1 %0h 1", l, g, rdc1, e);
        end
    endtask

    initial begin
        rst0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        last0 = '0; last1 = '0;
        @(posedge clk); #1;
        test_reset();
        test_read_latency();
        test_back_to_back();
        test_alias();
        test_violation();
        test_reset_mid();
        test_lat1_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
